// File: rtl/module_pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK_WIDTH CLA block is resolved per stage,
// with operands and partial sums skewed through the pipe and a single global stall.
module module_pipelined_cla_adder #(
  parameter int WIDTH       = 32,
  parameter int BLOCK_WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             sub_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int NUM_BLOCKS = WIDTH / BLOCK_WIDTH;

  if (BLOCK_WIDTH < 1 || WIDTH < BLOCK_WIDTH || (WIDTH % BLOCK_WIDTH) != 0) begin : g_bad_cfg
    $error("WIDTH must be a non-zero multiple of BLOCK_WIDTH");
  end

  // Result layout: {carry out, carry into block MSB, block sum}
  function automatic logic [BLOCK_WIDTH+1:0] cla_block(
    input logic [BLOCK_WIDTH-1:0] a,
    input logic [BLOCK_WIDTH-1:0] b,
    input logic                   cin
  );
    logic [BLOCK_WIDTH-1:0] g;
    logic [BLOCK_WIDTH-1:0] p;
    logic [BLOCK_WIDTH:0]   c;
    logic                   pp;
    logic                   cc;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLOCK_WIDTH; i++) begin
      cc = 1'b0;
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        cc = cc | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = cc | (pp & cin);
    end
    return {c[BLOCK_WIDTH], c[BLOCK_WIDTH-1], p ^ c[BLOCK_WIDTH-1:0]};
  endfunction

  logic w_adv;

  for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_stg
    localparam int LO = k * BLOCK_WIDTH;
    localparam int HI = LO + BLOCK_WIDTH;

    logic [WIDTH-1:LO]      w_a_in;
    logic [WIDTH-1:LO]      w_b_in;
    logic                   w_c_in;
    logic                   w_vld_in;
    logic [BLOCK_WIDTH+1:0] w_res;
    logic [HI-1:0]          w_sum_nxt;

    logic                   r_vld_p;
    logic                   r_c_p;
    logic [HI-1:0]          r_sum_p;

    // Stage boundary: stage 0 takes the port operands, later stages take the skew registers
    if (k == 0) begin : g_first
      assign w_a_in    = a_i;
      assign w_b_in    = sub_i ? ~b_i : b_i;
      assign w_c_in    = sub_i | carry_i;
      assign w_vld_in  = valid_i;
      assign w_sum_nxt = w_res[BLOCK_WIDTH-1:0];
    end else begin : g_next
      assign w_a_in    = g_stg[k-1].g_ops.r_a_p;
      assign w_b_in    = g_stg[k-1].g_ops.r_b_p;
      assign w_c_in    = g_stg[k-1].r_c_p;
      assign w_vld_in  = g_stg[k-1].r_vld_p;
      assign w_sum_nxt = {w_res[BLOCK_WIDTH-1:0], g_stg[k-1].r_sum_p};
    end

    assign w_res = cla_block(w_a_in[LO +: BLOCK_WIDTH], w_b_in[LO +: BLOCK_WIDTH], w_c_in);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_vld_p <= 1'b0;
      end else if (w_adv) begin
        r_vld_p <= w_vld_in;
      end
    end

    if (k < NUM_BLOCKS - 1) begin : g_ops
      logic [WIDTH-1:HI] r_a_p;
      logic [WIDTH-1:HI] r_b_p;

      always_ff @(posedge clk_i) begin
        if (w_adv) begin
          r_a_p   <= w_a_in[WIDTH-1:HI];
          r_b_p   <= w_b_in[WIDTH-1:HI];
          r_sum_p <= w_sum_nxt;
          r_c_p   <= w_res[BLOCK_WIDTH+1];
        end
      end
    end else begin : g_last
      logic r_ovf_p;
      logic r_zero_p;

      // Final stage doubles as the output register, so its data fields are reset too
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_sum_p  <= '0;
          r_c_p    <= 1'b0;
          r_ovf_p  <= 1'b0;
          r_zero_p <= 1'b0;
        end else if (w_adv) begin
          r_sum_p  <= w_sum_nxt;
          r_c_p    <= w_res[BLOCK_WIDTH+1];
          r_ovf_p  <= w_res[BLOCK_WIDTH+1] ^ w_res[BLOCK_WIDTH];
          r_zero_p <= (w_sum_nxt == '0);
        end
      end
    end
  end

  assign valid_o    = g_stg[NUM_BLOCKS-1].r_vld_p;
  assign sum_o      = g_stg[NUM_BLOCKS-1].r_sum_p;
  assign carry_o    = g_stg[NUM_BLOCKS-1].r_c_p;
  assign overflow_o = g_stg[NUM_BLOCKS-1].g_last.r_ovf_p;
  assign zero_o     = g_stg[NUM_BLOCKS-1].g_last.r_zero_p;

  assign w_adv   = ~valid_o | ready_i;
  assign ready_o = w_adv;

endmodule

// File: tb/tb_module_pipelined_cla_adder.sv
// Bench for the pipelined CLA adder: a 16/4 instance under a queue scoreboard with random
// traffic and backpressure, plus a single-block 8/8 instance.
module tb_module_pipelined_cla_adder;

  localparam int W  = 16;
  localparam int NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] a, b, sum;
  logic         cin, sub, vin, rdy_o, rdy_i, vout, co, ovf, zo;

  logic [7:0]   a8, b8, sum8;
  logic         cin8, sub8, vin8, rdy8_o, rdy8_i, vout8, co8, ovf8, zo8;

  module_pipelined_cla_adder #(.WIDTH(16), .BLOCK_WIDTH(4)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .carry_i(cin), .sub_i(sub),
    .valid_i(vin), .ready_o(rdy_o), .sum_o(sum), .carry_o(co), .overflow_o(ovf),
    .zero_o(zo), .valid_o(vout), .ready_i(rdy_i)
  );

  module_pipelined_cla_adder #(.WIDTH(8), .BLOCK_WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .a_i(a8), .b_i(b8), .carry_i(cin8), .sub_i(sub8),
    .valid_i(vin8), .ready_o(rdy8_o), .sum_o(sum8), .carry_o(co8), .overflow_o(ovf8),
    .zero_o(zo8), .valid_o(vout8), .ready_i(rdy8_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
    int           t;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  logic lat_on = 1'b0;
  logic stalled_prev = 1'b0;
  logic [19:0] held;

  // Reference: plain integer add/subtract, signed range test for overflow
  function automatic exp_t model16(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic s);
    exp_t e;
    logic [W:0] full;
    int sx, sy, r;
    sx = $signed(x);
    sy = $signed(y);
    if (s) begin
      e.s = x - y;
      e.c = (x >= y);
      r   = sx - sy;
    end else begin
      full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      e.s  = full[W-1:0];
      e.c  = full[W];
      r    = sx + sy + int'(ci);
    end
    e.v = (r > 32767) || (r < -32768);
    e.z = (e.s == '0);
    e.t = 0;
    return e;
  endfunction

  function automatic logic [10:0] model8(input logic [7:0] x, input logic [7:0] y,
                                         input logic ci, input logic s);
    logic [8:0] full;
    int r;
    if (s) begin
      full = {(x >= y), x - y};
      r    = int'($signed(x)) - int'($signed(y));
    end else begin
      full = {1'b0, x} + {1'b0, y} + {8'd0, ci};
      r    = int'($signed(x)) + int'($signed(y)) + int'(ci);
    end
    return {full[7:0], full[8], (r > 127) || (r < -128), full[7:0] == 8'd0};
  endfunction

  // One cycle on the 16-bit DUT; dir=1 pushes the supplied expectation instead of the model
  task automatic cycle(input logic v, input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic ci, input logic si, input logic ri,
                       input logic dir, input exp_t de);
    exp_t e;
    @(negedge clk);
    vin = v; a = ai; b = bi; cin = ci; sub = si; rdy_i = ri;
    #1;
    cyc++;
    check_eq("ready_o", {31'd0, rdy_o}, {31'd0, ~vout | ri});
    if (stalled_prev) check_eq("stall_hold", {12'd0, sum, co, ovf, zo, vout}, {12'd0, held});
    if (vout && ri) begin
      if (q.size() == 0) begin
        check_eq("stale_valid", {31'd0, vout}, 32'd0);
      end else begin
        e = q.pop_front();
        check_eq("sum", {16'd0, sum}, {16'd0, e.s});
        check_eq("flags_c_v_z", {29'd0, co, ovf, zo}, {29'd0, e.c, e.v, e.z});
        if (lat_on) check_eq("latency", cyc - e.t, NB);
      end
    end
    if (v && rdy_o) begin
      e   = dir ? de : model16(ai, bi, ci, si);
      e.t = cyc;
      q.push_back(e);
    end
    stalled_prev = vout & ~ri;
    held = {sum, co, ovf, zo, vout};
  endtask

  task automatic idle(input int n);
    exp_t d;
    d = '{default: '0};
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vin = 1'b0; rdy_i = 1'b1; vin8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_outputs", {12'd0, sum, co, ovf, zo, vout}, 32'd0);
    check_eq("rst_ready", {31'd0, rdy_o}, 32'd1);
    check_eq("rst_valid8", {31'd0, vout8}, 32'd0);
    q.delete();
    stalled_prev = 1'b0;
  endtask

  task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic ci,
                       input logic s, input logic [10:0] exp);
    @(negedge clk);
    vin8 = 1'b1; a8 = x; b8 = y; cin8 = ci; sub8 = s;
    @(posedge clk);
    #1;
    check_eq("nb1_valid", {31'd0, vout8}, 32'd1);
    check_eq("nb1_result", {21'd0, sum8, co8, ovf8, zo8}, {21'd0, exp});
    @(negedge clk);
    vin8 = 1'b0;
    @(posedge clk);
    #1;
    check_eq("nb1_bubble", {31'd0, vout8}, 32'd0);
  endtask

  initial begin
    exp_t d;
    logic [W-1:0] ra, rb;
    d = '{default: '0};
    rst = 1'b1; vin = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; rdy_i = 1'b1;
    vin8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; rdy8_i = 1'b1;
    do_reset();

    // Directed vectors with fixed expectations, full latency checked
    lat_on = 1'b1;
    d = '{s: 16'h0000, c: 1'b1, v: 1'b0, z: 1'b1, t: 0};
    cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, d);
    d = '{s: 16'h8000, c: 1'b0, v: 1'b1, z: 1'b0, t: 0};
    cycle(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, d);
    d = '{s: 16'hFFFE, c: 1'b0, v: 1'b0, z: 1'b0, t: 0};
    cycle(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 1'b1, d);
    d = '{s: 16'h0000, c: 1'b1, v: 1'b0, z: 1'b1, t: 0};
    cycle(1'b1, 16'h1234, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b1, d);
    idle(NB + 2);
    check_eq("directed_drained", q.size(), 0);

    // Back-to-back random stream
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      cycle(1'b1, ra, rb, 1'($urandom), 1'($urandom), 1'b1, 1'b0, d);
    end
    idle(NB + 2);
    check_eq("b2b_drained", q.size(), 0);

    // Random valid bubbles and random backpressure
    lat_on = 1'b0;
    for (int i = 0; i < 400; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      cycle(1'($urandom), ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, d);
    end
    idle(NB + 4);
    check_eq("bp_drained", q.size(), 0);

    // Reset with three transactions in flight; nothing stale may follow
    for (int i = 0; i < 3; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      cycle(1'b1, ra, rb, 1'b0, 1'b0, 1'b1, 1'b0, d);
    end
    do_reset();
    idle(2 * NB);
    lat_on = 1'b1;
    cycle(1'b1, 16'h00FF, 16'h0F01, 1'b1, 1'b0, 1'b1, 1'b0, d);
    idle(NB + 2);
    check_eq("post_rst_drained", q.size(), 0);

    // Single-block configuration
    send8(8'h80, 8'h80, 1'b0, 1'b0, {8'h00, 1'b1, 1'b1, 1'b1});
    send8(8'h05, 8'h07, 1'b1, 1'b1, {8'hFE, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 8; i++) begin
      logic [7:0] x, y;
      logic ci, s;
      x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom); s = 1'($urandom);
      send8(x, y, ci, s, model8(x, y, ci, s));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
